// File: rtl/frame_playback_if.sv
// Control, camera-stream and frame-buffer read signals of frame_playback.
// master is the playback engine; slave is whatever drives it and models the buffer.
interface frame_playback_if #(
    parameter int unsigned W_PW        = 10,
    parameter int unsigned W_PH        = 9,
    parameter int unsigned W_AFRAMEBUF = 16,
    parameter int unsigned W1          = 7
);
    logic [W_PW:0]        pic_width;
    logic [W_PH:0]        pic_height;
    logic                 play_go;
    logic                 play_ready;
    logic                 busy;
    logic                 cam_vsync_o;
    logic                 cam_href_o;
    logic [W1:0]          cam_data_o;
    logic [W_AFRAMEBUF:0] ab_frame_buf;
    logic                 cenb_frame_buf;
    logic [W1:0]          qb_frame_buf;

    modport master (
        input  pic_width, pic_height, play_go, qb_frame_buf,
        output play_ready, busy, cam_vsync_o, cam_href_o, cam_data_o,
               ab_frame_buf, cenb_frame_buf
    );

    modport slave (
        output pic_width, pic_height, play_go, qb_frame_buf,
        input  play_ready, busy, cam_vsync_o, cam_href_o, cam_data_o,
               ab_frame_buf, cenb_frame_buf
    );
endinterface

// File: rtl/frame_playback.sv
// Replays a stored luma frame from the frame buffer as a vsync/href/Y camera stream.
// Sync and href share one 3-cycle state-to-pin pipeline so their relative timing is exact.
module frame_playback #(
    parameter int unsigned W_PW           = 10,
    parameter int unsigned W_PH           = 9,
    parameter int unsigned W_AFRAMEBUF    = 16,
    parameter int unsigned W1             = 7,
    parameter int unsigned FRAME_BUF_LINE = 640,
    parameter int unsigned H_BLANK        = 16,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BACK         = 2,
    parameter int unsigned V_FRONT        = 2
) (
    input  logic              clk,
    input  logic              rst,
    frame_playback_if.master  bus
);
    localparam int unsigned PW = W_PW + 1;
    localparam int unsigned PH = W_PH + 1;
    localparam int unsigned AW = W_AFRAMEBUF + 1;
    localparam int unsigned DW = W1 + 1;
    localparam int unsigned HW = PW + 1;
    localparam int unsigned LW = PH + 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t          state, state_n;
    state_t          after_sync_c, after_back_c, after_active_c;
    logic [HW-1:0]   h_cnt;
    logic [LW-1:0]   line_cnt;
    logic [PW-1:0]   pw_lat;
    logic [PH-1:0]   ph_lat;
    logic            go_pend;

    logic [HW-1:0]   line_len_c;
    logic [LW-1:0]   dur_c;
    logic            eol_c, last_line_c, start_c, done_c, rd_c;
    logic [AW-1:0]   addr_c;

    logic            vs_d1, vs_d2, rd_d1;
    logic            play_ready_r, busy_r, vsync_r, href_r, cenb_r;
    logic [DW-1:0]   data_r;
    logic [AW-1:0]   ab_r;

    // Next-state: each phase lasts a whole number of lines; empty phases are skipped.
    always_comb begin
        state_n        = state;
        start_c        = 1'b0;
        dur_c          = '0;
        line_len_c     = HW'(pw_lat) + HW'(H_BLANK);
        eol_c          = (h_cnt == line_len_c - HW'(1));
        after_active_c = (V_FRONT != 0) ? VFRONT : IDLE;
        after_back_c   = (ph_lat != '0) ? ACTIVE : after_active_c;
        after_sync_c   = (V_BACK != 0) ? VBACK : after_back_c;

        case (state)
            VSYNC:   dur_c = LW'(V_SYNC);
            VBACK:   dur_c = LW'(V_BACK);
            ACTIVE:  dur_c = LW'(ph_lat);
            VFRONT:  dur_c = LW'(V_FRONT);
            default: dur_c = '0;
        endcase
        last_line_c = eol_c && (line_cnt == dur_c - LW'(1));

        case (state)
            IDLE: begin
                if (go_pend) begin
                    state_n = VSYNC;
                    start_c = 1'b1;
                end
            end
            VSYNC:   if (last_line_c) state_n = after_sync_c;
            VBACK:   if (last_line_c) state_n = after_back_c;
            ACTIVE:  if (last_line_c) state_n = after_active_c;
            VFRONT:  if (last_line_c) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        done_c = (state != IDLE) && (state_n == IDLE);
        rd_c   = (state == ACTIVE) && (h_cnt < HW'(pw_lat));
        addr_c = AW'(line_cnt) * AW'(FRAME_BUF_LINE) + AW'(h_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            go_pend  <= 1'b0;
            pw_lat   <= '0;
            ph_lat   <= '0;
            h_cnt    <= '0;
            line_cnt <= '0;
        end else begin
            state   <= state_n;
            go_pend <= (go_pend | bus.play_go) & ~start_c;
            if (start_c) begin
                pw_lat   <= bus.pic_width;
                ph_lat   <= bus.pic_height;
                h_cnt    <= '0;
                line_cnt <= '0;
            end else if (state != IDLE) begin
                if (eol_c) begin
                    h_cnt    <= '0;
                    line_cnt <= (state_n != state) ? '0 : line_cnt + LW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

    // Read issue -> buffer latency -> pin register; vsync rides an equal-length delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            play_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            vs_d1        <= 1'b0;
            vs_d2        <= 1'b0;
            vsync_r      <= 1'b0;
            rd_d1        <= 1'b0;
            href_r       <= 1'b0;
            data_r       <= '0;
            ab_r         <= '0;
            cenb_r       <= 1'b1;
        end else begin
            play_ready_r <= done_c;
            busy_r       <= (state_n != IDLE) | done_c;
            vs_d1        <= (state == VSYNC);
            vs_d2        <= vs_d1;
            vsync_r      <= vs_d2;
            cenb_r       <= ~rd_c;
            if (rd_c) ab_r <= addr_c;
            rd_d1        <= ~cenb_r;
            href_r       <= rd_d1;
            if (rd_d1) data_r <= bus.qb_frame_buf;
        end
    end

    assign bus.play_ready     = play_ready_r;
    assign bus.busy           = busy_r;
    assign bus.cam_vsync_o    = vsync_r;
    assign bus.cam_href_o     = href_r;
    assign bus.cam_data_o     = data_r;
    assign bus.ab_frame_buf   = ab_r;
    assign bus.cenb_frame_buf = cenb_r;
endmodule

// File: tb/tb_frame_playback.sv
// Bench for frame_playback: logs every output event per cycle and compares the logs
// against a per-frame timeline computed from line/phase arithmetic.
module tb_frame_playback;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int HB = 4;
    localparam int STRIDE = 8;
    localparam logic [29:0] RST_VEC = 30'h1;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    frame_playback_if bus ();

    frame_playback #(
        .FRAME_BUF_LINE(STRIDE), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame buffer: one-cycle latency, content equals the low address byte.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.qb_frame_buf <= '0;
        else if (!bus.cenb_frame_buf) bus.qb_frame_buf <= bus.ab_frame_buf[7:0];
    end

    // Logs: 0 vsync cycles, 1 href cycles, 2 href data, 3 read cycles, 4 read addr, 5 ready, 6 busy
    int    obs[7][$];
    int    expq[7][$];
    string names[7] = '{"vsync", "href_cyc", "href_data", "rd_cyc", "rd_addr", "ready", "busy"};

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cam_vsync_o) obs[0].push_back(cyc);
            if (bus.cam_href_o) begin
                obs[1].push_back(cyc);
                obs[2].push_back(int'(bus.cam_data_o));
            end
            if (!bus.cenb_frame_buf) begin
                obs[3].push_back(cyc);
                obs[4].push_back(int'(bus.ab_frame_buf));
            end
            if (bus.play_ready) obs[5].push_back(cyc);
            if (bus.busy) obs[6].push_back(cyc);
        end
    end

    // Expected timeline of one frame whose VSYNC phase begins at cycle e; returns ready cycle.
    function automatic int add_frame(int e, int pw, int ph);
        int l;
        int n;
        l = pw + HB;
        n = VS + VB + ph + VF;
        for (int c = 0; c < VS * l; c++) expq[0].push_back(e + 3 + c);
        for (int v = 0; v < ph; v++) begin
            for (int h = 0; h < pw; h++) begin
                int base;
                base = e + (VS + VB + v) * l + h;
                expq[1].push_back(base + 3);
                expq[2].push_back((v * STRIDE + h) % 256);
                expq[3].push_back(base + 1);
                expq[4].push_back(v * STRIDE + h);
            end
        end
        expq[5].push_back(e + n * l);
        for (int c = 0; c <= n * l; c++) expq[6].push_back(e + c);
        return e + n * l;
    endfunction

    function automatic int first_diff(int k);
        int n;
        n = (obs[k].size() > expq[k].size()) ? obs[k].size() : expq[k].size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs[k].size() || i >= expq[k].size()) return i;
            if (obs[k][i] != expq[k][i]) return i;
        end
        return -1;
    endfunction

    function automatic int obs_at(int k, int i);
        return (i >= 0 && i < obs[k].size()) ? obs[k][i] : -1;
    endfunction

    function automatic int exp_at(int k, int i);
        return (i >= 0 && i < expq[k].size()) ? expq[k][i] : -1;
    endfunction

    task automatic clear_logs();
        for (int k = 0; k < 7; k++) begin
            obs[k].delete();
            expq[k].delete();
        end
    endtask

    task automatic pulse_go(output int t);
        @(posedge clk); #1;
        bus.play_go = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        bus.play_go = 1'b0;
    endtask

    task automatic wait_ready(input int n, input int budget, output bit to);
        int k;
        k = 0;
        while (obs[5].size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        to = (obs[5].size() < n);
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [29:0] got;
        rst = 1'b1;
        bus.play_go = 1'b0;
        bus.pic_width = '0;
        bus.pic_height = '0;
        repeat (3) @(posedge clk);
        #1;
        got = {bus.play_ready, bus.busy, bus.cam_vsync_o, bus.cam_href_o, bus.cam_data_o,
               bus.ab_frame_buf, bus.cenb_frame_buf};
        checks++;
        if (got !== RST_VEC) begin
            errors++;
            $display("FAIL reset.outputs got %h expected %h", got, RST_VEC);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic();
        int t;
        int r;
        bit to;
        clear_logs();
        bus.pic_width = 11'd4;
        bus.pic_height = 10'd3;
        pulse_go(t);
        r = add_frame(t + 2, 4, 3);
        wait_ready(1, 400, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL basic.timeout got no play_ready expected one"); end
        checks++;
        if (r - (t + 2) !== 56) begin errors++; $display("FAIL basic.frame_len got %0d expected 56", r - t - 2); end
        for (int k = 0; k < 7; k++) begin
            int d;
            d = first_diff(k);
            checks++;
            if (d !== -1) begin
                errors++;
                $display("FAIL basic.%s idx %0d got %0d expected %0d", names[k], d, obs_at(k, d), exp_at(k, d));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int r1;
        int pw;
        int ph;
        bit to;
        clear_logs();
        pw = int'($urandom_range(2, 6));
        ph = int'($urandom_range(2, 4));
        bus.pic_width = 11'(pw);
        bus.pic_height = 10'(ph);
        pulse_go(t);
        r1 = add_frame(t + 2, pw, ph);
        repeat (3) begin
            repeat ($urandom_range(1, 10)) @(posedge clk);
            #1 bus.play_go = 1'b1;
            @(posedge clk);
            #1 bus.play_go = 1'b0;
        end
        void'(add_frame(r1 + 1, pw, ph));
        wait_ready(2, 800, to);
        repeat (40) @(posedge clk);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL b2b.timeout got %0d ready expected 2", obs[5].size()); end
        for (int k = 0; k < 7; k++) begin
            int d;
            d = first_diff(k);
            checks++;
            if (d !== -1) begin
                errors++;
                $display("FAIL b2b.%s idx %0d got %0d expected %0d", names[k], d, obs_at(k, d), exp_at(k, d));
            end
        end
    endtask

    task automatic test_go_collision();
        int t;
        bit to;
        clear_logs();
        bus.pic_width = 11'd3;
        bus.pic_height = 10'd2;
        @(posedge clk); #1;
        bus.play_go = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.play_go = 1'b0;
        void'(add_frame(t + 2, 3, 2));
        wait_ready(1, 400, to);
        repeat (40) @(posedge clk);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL collide.timeout got no play_ready expected one"); end
        for (int k = 0; k < 7; k++) begin
            int d;
            d = first_diff(k);
            checks++;
            if (d !== -1) begin
                errors++;
                $display("FAIL collide.%s idx %0d got %0d expected %0d", names[k], d, obs_at(k, d), exp_at(k, d));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int e;
        bit to;
        logic [29:0] got;
        clear_logs();
        bus.pic_width = 11'd4;
        bus.pic_height = 10'd3;
        pulse_go(t);
        e = t + 2;
        while (cyc < e + 10) @(posedge clk);
        #1 bus.play_go = 1'b1;
        @(posedge clk);
        #1 bus.play_go = 1'b0;
        while (cyc < e + 42) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        got = {bus.play_ready, bus.busy, bus.cam_vsync_o, bus.cam_href_o, bus.cam_data_o,
               bus.ab_frame_buf, bus.cenb_frame_buf};
        checks++;
        if (got !== RST_VEC) begin
            errors++;
            $display("FAIL rstmid.async got %h expected %h", got, RST_VEC);
        end
        checks++;
        if (obs[3].size() !== 10) begin
            errors++;
            $display("FAIL rstmid.reads_before got %0d expected 10", obs[3].size());
        end
        repeat (3) @(posedge clk);
        checks++;
        if (obs[5].size() !== 0) begin
            errors++;
            $display("FAIL rstmid.ready got %0d pulses expected 0", obs[5].size());
        end
        clear_logs();
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        checks++;
        if (obs[6].size() !== 0) begin
            errors++;
            $display("FAIL rstmid.pending_dropped got %0d busy cycles expected 0", obs[6].size());
        end
        clear_logs();
        pulse_go(t);
        void'(add_frame(t + 2, 4, 3));
        wait_ready(1, 400, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL rstmid.timeout got no play_ready expected one"); end
        for (int k = 0; k < 7; k++) begin
            int d;
            d = first_diff(k);
            checks++;
            if (d !== -1) begin
                errors++;
                $display("FAIL rstmid.%s idx %0d got %0d expected %0d", names[k], d, obs_at(k, d), exp_at(k, d));
            end
        end
    endtask

    task automatic test_zero_height();
        int t;
        bit to;
        clear_logs();
        bus.pic_width = 11'd4;
        bus.pic_height = 10'd0;
        pulse_go(t);
        void'(add_frame(t + 2, 4, 0));
        wait_ready(1, 400, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL zeroh.timeout got no play_ready expected one"); end
        checks++;
        if (obs[1].size() + obs[3].size() !== 0) begin
            errors++;
            $display("FAIL zeroh.activity got %0d href/read cycles expected 0", obs[1].size() + obs[3].size());
        end
        for (int k = 0; k < 7; k++) begin
            int d;
            d = first_diff(k);
            checks++;
            if (d !== -1) begin
                errors++;
                $display("FAIL zeroh.%s idx %0d got %0d expected %0d", names[k], d, obs_at(k, d), exp_at(k, d));
            end
        end
    endtask

    task automatic test_width_change();
        int t;
        bit to;
        clear_logs();
        bus.pic_width = 11'd5;
        bus.pic_height = 10'd2;
        pulse_go(t);
        void'(add_frame(t + 2, 5, 2));
        repeat (6) @(posedge clk);
        #1;
        bus.pic_width = 11'd3;
        bus.pic_height = 10'd4;
        wait_ready(1, 400, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL wchg.timeout1 got no play_ready expected one"); end
        pulse_go(t);
        void'(add_frame(t + 2, 3, 4));
        wait_ready(2, 400, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL wchg.timeout2 got %0d ready expected 2", obs[5].size()); end
        for (int k = 0; k < 7; k++) begin
            int d;
            d = first_diff(k);
            checks++;
            if (d !== -1) begin
                errors++;
                $display("FAIL wchg.%s idx %0d got %0d expected %0d", names[k], d, obs_at(k, d), exp_at(k, d));
            end
        end
    endtask

    task automatic test_random();
        int t;
        int pw;
        int ph;
        bit to;
        for (int it = 0; it < 5; it++) begin
            clear_logs();
            pw = int'($urandom_range(0, 8));
            ph = int'($urandom_range(0, 5));
            bus.pic_width = 11'(pw);
            bus.pic_height = 10'(ph);
            repeat ($urandom_range(0, 7)) @(posedge clk);
            pulse_go(t);
            void'(add_frame(t + 2, pw, ph));
            wait_ready(1, 400, to);
            checks++;
            if (to !== 1'b0) begin errors++; $display("FAIL rand%0d.timeout w=%0d h=%0d got no play_ready", it, pw, ph); end
            for (int k = 0; k < 7; k++) begin
                int d;
                d = first_diff(k);
                checks++;
                if (d !== -1) begin
                    errors++;
                    $display("FAIL rand%0d.%s w=%0d h=%0d idx %0d got %0d expected %0d",
                             it, names[k], pw, ph, d, obs_at(k, d), exp_at(k, d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_go_collision();
        test_reset_mid();
        test_zero_height();
        test_width_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_playback.md
Name: frame_playback

Overview:
- Reads a stored luma frame out of the frame buffer and re-emits it as a camera-style stream: vsync, href and 8-bit Y data.
- It is the transmit-side counterpart of the camera capture path. It uses the same frame-buffer addressing (row stride FRAME_BUF_LINE) and the same sync/href conventions, so its output can loop back into capture or feed a display/debug port.
- Drives the frame-buffer read port: active-low enable, 1-cycle read latency.

Parameters:
- W_PW, 10, MSB index of pic_width.
- W_PH, 9, MSB index of pic_height.
- W_AFRAMEBUF, 16, MSB index of frame-buffer address.
- W1, 7, MSB index of pixel data.
- FRAME_BUF_LINE, 640, address stride per row.
- H_BLANK, 16, href-low cycles after each line's active pixels (>=1).
- V_SYNC, 2, lines with vsync high (>=1).
- V_BACK, 2, blank lines after vsync, before first active line.
- V_FRONT, 2, blank lines after last active line.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- pic_width  in  W_PW+1  active pixels per line; sampled at frame start.
- pic_height  in  W_PH+1  active lines per frame; sampled at frame start.
- play_go  in  1  1-cycle request to play one frame.
- play_ready  out  1  1-cycle pulse when a frame's front porch completes.
- busy  out  1  high while a frame is in progress (FSM not IDLE).
- cam_vsync_o  out  1  vsync, active-high.
- cam_href_o  out  1  high exactly on valid-pixel cycles.
- cam_data_o  out  W1+1  pixel Y value.
- ab_frame_buf  out  W_AFRAMEBUF+1  read address.
- cenb_frame_buf  out  1  read enable, active-low.
- qb_frame_buf  in  W1+1  read data, valid the cycle after cenb_frame_buf low.

Behaviour:
- Reset values: play_ready=0, busy=0, cam_vsync_o=0, cam_href_o=0, cam_data_o=0, ab_frame_buf=0, cenb_frame_buf=1.
- Reset asserted mid-frame aborts immediately. All counters clear, FSM goes to IDLE and any pending go is dropped.
- Line timing: every line is L = pic_width + H_BLANK cycles, including sync and blank lines.
  - h counter runs 0..L-1.
  - Active cycles are those with h < pic_width.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE -> VSYNC when a go is pending. On entry: pic_width/pic_height latched; h and line counters cleared.
  - VSYNC lasts V_SYNC lines, then VBACK.
  - VBACK lasts V_BACK lines (0 means skip straight to ACTIVE), then ACTIVE.
  - ACTIVE lasts pic_height lines, then VFRONT.
  - VFRONT lasts V_FRONT lines, then IDLE.
  - play_ready pulses on the VFRONT -> IDLE transition cycle, registered.
  - If pic_height==0, ACTIVE is skipped: no href, no reads.
- go pending flag:
  - Set by play_go; cleared on the IDLE -> VSYNC transition.
  - play_go during a frame is latched; the next frame starts the cycle after return to IDLE.
  - Multiple go pulses while pending collapse to one.
  - play_go coinciding with the transition out of IDLE is consumed by that frame, not re-queued.
- Read port: in ACTIVE with h < pic_width (cycle N):
  - cenb_frame_buf=0 and ab_frame_buf = v*FRAME_BUF_LINE + h, registered, visible at N+1.
  - v is the 0-based active-line index.
  - Address arithmetic is full width, truncated to W_AFRAMEBUF+1.
  - cenb_frame_buf=1 in all other cycles; ab_frame_buf holds its last value.
- Output pipeline: if cenb_frame_buf is low at cycle M, qb_frame_buf is valid at M+1, and cam_data_o <= qb_frame_buf with cam_href_o=1 at M+2.
  - cam_vsync_o is delayed by the same total pipeline (state -> output 3 cycles), so sync/href relative timing is exact.
  - cam_data_o holds its last value while href is low.
- First vsync edge: play_go at cycle T -> pending at T+1 -> VSYNC at T+2 -> cam_vsync_o high at T+5.
- pic_width==0: lines are H_BLANK long; no href pulses.
- busy is high from entry to VSYNC through the play_ready cycle.

Test Plan:
- Params FRAME_BUF_LINE=8, H_BLANK=4, V_SYNC=2, V_BACK=1, V_FRONT=1; pic 4x3; single play_go.
  - Required: vsync high exactly 16 cycles.
  - Required: 3 href bursts of 4 cycles at 8-cycle spacing.
  - Required: addresses 0-3, 8-11, 16-19.
  - Required: play_ready exactly once, 56 cycles after VSYNC entry.
- Buffer model returns data = address[7:0] -> cam_data_o sequence 0,1,2,3,8,9,10,11,16,17,18,19, each aligned with cam_href_o=1.
- play_go pulsed 3 times mid-frame -> exactly one extra frame, starting 1 cycle after IDLE is re-entered; 2 play_ready pulses total.
- rst asserted during line 2 of ACTIVE:
  - Required: all outputs at reset values asynchronously.
  - Required: no play_ready.
  - Required: a new play_go after release produces a clean full frame.
- pic_height=0, pic_width=4 -> vsync and porches still emitted, zero href/cenb activity, play_ready asserted.
- pic_width changed mid-frame -> current frame keeps the latched width; the next frame uses the new width.
